// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   occ_e          : occupancy state of a skid stage (0, 1 or 2 entries held)
//   *_CTRL_W/_DATA_W : default field widths for each stage boundary
//   occ_has_room() : whether a stage in the given state can accept an entry
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int unsigned IF_ID_CTRL_W  = 4;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 24;
  localparam int unsigned ID_EX_DATA_W  = 128;
  localparam int unsigned EX_MEM_CTRL_W = 16;
  localparam int unsigned EX_MEM_DATA_W = 96;
  localparam int unsigned MEM_WB_CTRL_W = 8;
  localparam int unsigned MEM_WB_DATA_W = 64;

  function automatic logic occ_has_room(occ_e s);
    return s != OCC_TWO;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid + ctrl + data.
//   clk, rst_n : clock, async active-low reset (clears everything)
//   load_i     : capture ctrl_i/data_i and mark the slot valid
//   clear_i    : turn the slot into a bubble (valid and ctrl zeroed, data kept);
//                wins over load_i
//   ctrl_i/data_i : entry to capture
//   valid_o/ctrl_o/data_o : held entry
module pipe_slot #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      // Data deliberately left alone: a bubble only needs a zero ctrl field.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Full throughput under backpressure without any combinational out_ready->in_ready
// path; flush turns every held entry (and one accepted the same cycle) into bubbles.
//   clk, rst_n           : clock, async active-low reset
//   flush                : drop all held entries
//   in_valid/in_ready    : upstream handshake, in_ctrl/in_data carried entry
//   out_valid/out_ready  : downstream handshake, out_ctrl/out_data head entry
//   out_ctrl             : forced to zero whenever out_valid is low
//   occupancy            : entries held (0..2)
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W,
  parameter int unsigned DATA_W = EX_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_e state_d, state_q;

  logic              head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
  logic [DATA_W-1:0] head_data, skid_data, head_data_in;
  logic              head_load, head_clear, head_from_skid;
  logic              skid_load, skid_clear;
  logic              acc, take;

  // in_ready comes from registered state only.
  assign in_ready = occ_has_room(state_q);
  assign acc      = in_valid & in_ready;
  assign take     = head_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = OCC_EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (acc) begin
            head_load = 1'b1;
            state_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && take) begin
            head_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_d   = OCC_TWO;
          end else if (take) begin
            head_clear = 1'b1;
            state_d    = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (take) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = OCC_ONE;
          end
        end
        default: begin
          state_d    = OCC_EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_data_in = head_from_skid ? skid_data : in_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (head_load),
    .clear_i (head_clear),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_valid),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  // The skid slot holds a live entry exactly when the stage is full.
  skid_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid == (state_q == OCC_TWO));

  assign out_valid = head_valid;
  assign out_ctrl  = head_valid ? head_ctrl : '0;
  assign out_data  = head_data;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int failures = 0;

  pipe_skid_stage #(
    .CTRL_W (CW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {16'hBEEF, c, 32'h1234_0000 | 32'(c), 32'(c) ^ 32'hFFFF_FFFF};
  endfunction

  // Reference model: a FIFO of at most two entries.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  ent_t m_ent;
  bit   m_acc, m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_acc  = in_valid && (q.size() < 2);
      m_take = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (m_take) void'(q.pop_front());
        if (m_acc) begin
          m_ent.c = in_ctrl;
          m_ent.d = in_data;
          q.push_back(m_ent);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", out_valid, q.size() > 0);
    check("model_in_ready", in_ready, q.size() < 2);
    check("model_occupancy", occupancy, q.size());
    if (q.size() > 0) begin
      check("model_out_ctrl", out_ctrl, q[0].c);
      check("model_out_data", out_data, q[0].d);
    end else begin
      check("model_bubble_ctrl", out_ctrl, 0);
    end
  end

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = mk_data(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, before any clock edge.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    step();

    // Streaming with out_ready high.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CW'(k));
      step();
      check("stream_ctrl", out_ctrl, k);
      check("stream_occ", occupancy, 1);
      check("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, '0);
    step();
    check("stream_drain_occ", occupancy, 0);

    // Backpressure: A, B, C with out_ready low.
    out_ready = 1'b0;
    drive(1'b1, 16'h00A1);
    step();
    check("bp_occ1", occupancy, 1);
    drive(1'b1, 16'h00B2);
    step();
    check("bp_occ2", occupancy, 2);
    check("bp_in_ready0", in_ready, 0);
    check("bp_head_a", out_ctrl, 16'h00A1);
    drive(1'b1, 16'h00C3);
    step();
    check("bp_hold_occ", occupancy, 2);
    check("bp_hold_a", out_ctrl, 16'h00A1);
    out_ready = 1'b1;
    step();
    check("bp_then_b", out_ctrl, 16'h00B2);
    check("bp_then_b_occ", occupancy, 1);
    step();
    check("bp_then_c", out_ctrl, 16'h00C3);
    check("bp_then_c_data", out_data, mk_data(16'h00C3));
    drive(1'b0, '0);
    step();
    check("bp_drain_occ", occupancy, 0);

    // Flush with two entries held and D offered.
    out_ready = 1'b0;
    drive(1'b1, 16'h00E1);
    step();
    drive(1'b1, 16'h00E2);
    step();
    check("fl_occ2", occupancy, 2);
    drive(1'b1, 16'h00DD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    check("fl_occ0", occupancy, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    out_ready = 1'b1;
    step();
    step();
    check("fl_no_d", out_valid, 0);

    // Flush coinciding with a take.
    out_ready = 1'b0;
    drive(1'b1, 16'h00F1);
    step();
    drive(1'b0, '0);
    check("flt_occ1", occupancy, 1);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flt_occ0", occupancy, 0);
    check("flt_in_ready", in_ready, 1);

    // Asynchronous reset with the stage full.
    out_ready = 1'b0;
    drive(1'b1, 16'h0071);
    step();
    drive(1'b1, 16'h0072);
    step();
    drive(1'b0, '0);
    check("ar_occ2", occupancy, 2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_ctrl", out_ctrl, 0);
    check("ar_out_data", out_data, 0);
    check("ar_occ", occupancy, 0);
    check("ar_in_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h00E5);
    step();
    check("ar_e_valid", out_valid, 1);
    check("ar_e_ctrl", out_ctrl, 16'h00E5);
    drive(1'b0, '0);
    step();
    check("ar_e_drained", occupancy, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register: successor of the fixed-field EX/MEM latch. Carries an opaque control field and data payload between any two pipeline stages with a valid/ready handshake, a two-entry skid buffer for full throughput under backpressure, and a flush that turns all held entries into bubbles. Sits between EX and MEM, and is reusable at IF/ID, ID/EX and MEM/WB by changing widths.

## Interface
- CTRL_W, 16: control bits per entry (RegWrite, MEMWrite, WBSrc, InsType, RegDes …); zeroed on bubble/flush.
- DATA_W, 96: payload bits per entry (result, store data, link address …); never cleared except by reset.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all held entries and any entry accepted this cycle.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_ctrl/out_data hold a live entry.
- out_ready  in  1  downstream consumes; transfer when out_valid & out_ready.
- out_ctrl  out  CTRL_W  head control field; all-zero whenever out_valid=0.
- out_data  out  DATA_W  head payload.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Storage: head slot (drives outputs) and skid slot. Each slot holds valid, ctrl, data.
- State = occupancy: EMPTY(0), ONE(1), TWO(2). in_ready = (state != TWO), decoded from registered state only; no combinational path from out_ready to in_ready.
- acc = in_valid & in_ready; take = out_valid & out_ready.
- EMPTY: acc -> head <= in, ONE; else stay.
- ONE: acc & take -> head <= in, ONE. acc & !take -> skid <= in, TWO. !acc & take -> EMPTY. neither -> hold.
- TWO: in_ready=0. take -> head <= skid, skid cleared, ONE; else hold.
- flush (highest priority): next state EMPTY; head and skid valid and ctrl cleared; data fields keep old value. An entry accepted in the flush cycle is dropped. A take in the flush cycle counts as completed downstream.
- Ordering strictly FIFO; no entry duplicated or lost except by flush.
- Cleared slots force ctrl = 0, so a bubble is a NOP downstream.

## Timing
- Reset (rst_n low, async): state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid zeroed, occupancy 0, in_ready 1. Outputs settle without a clock edge. Upstream must hold in_valid low while rst_n is low; deassertion is synchronised upstream of this block.
- Latency: accept at edge N -> out_valid at edge N (visible cycle N+1) when EMPTY or ONE-with-take; one-cycle latency.
- Throughput: one entry/cycle sustained with out_ready held high; in_ready drops one cycle after downstream stalls with one entry held.
- Reset asserted mid-transfer: all entries lost, no partial update.
- flush with rst_n low: reset dominates.

## Structure
- Shared package pipe_pkg: typedef of the 2-bit occupancy state enum (OCC_EMPTY, OCC_ONE, OCC_TWO) and default CTRL_W/DATA_W constants for each stage boundary (EX_MEM_CTRL_W, EX_MEM_DATA_W …).
- One sub-module: pipe_slot (valid + ctrl + data register with load, clear-ctrl, async reset), instantiated twice (head, skid).

## Test plan
- Reset: rst_n low with in_valid=0 -> out_valid 0, out_ctrl 0, out_data 0, occupancy 0, in_ready 1, immediately and without clock.
- Streaming: out_ready=1, push ctrl 0x0001..0x0008 on consecutive cycles -> same sequence on out_ctrl one cycle later, occupancy never > 1, in_ready constantly 1.
- Backpressure: push A,B,C with out_ready=0 -> A accepted, B to skid, occupancy 2, in_ready 0, C held upstream; raise out_ready -> A, B, C emerge in order, no gap after A.
- Flush with two held: occupancy 2, pulse flush with in_valid=1 carrying D -> next cycle occupancy 0, out_valid 0, out_ctrl 0x0000, D never appears.
- Flush with simultaneous take: ONE with out_ready=1, flush=1 -> entry counted consumed, next cycle EMPTY, in_ready 1.
- Async reset mid-stream: occupancy 2, drop rst_n between edges -> outputs zero before next edge; release, push E -> E out after one cycle.
